// File: rtl/i2c_pkg.sv
// Shared types and frame-geometry constants for the I2C write engine.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BIT,
        ST_ACK,
        ST_STOP,
        ST_DONE
    } i2c_state_e;

    localparam int START_Q    = 4;
    localparam int BYTE_Q     = 36;
    localparam int STOP_Q     = 4;
    localparam int FRAME_Q    = 116;
    localparam int FRAME_BITS = 24;

endpackage

// File: rtl/i2c_qtick_gen.sv
// Free-running quarter-bit divider: one-cycle tick every QDIV clocks, restarted by a synchronous clear.
module i2c_qtick_gen #(
    parameter int QDIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(QDIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || (cnt_q == CNT_MAX)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_MAX) && !clr;

endmodule

// File: rtl/i2c_write_engine.sv
// Bit-level I2C master writing one 24-bit {address, sub-address, data} frame per GO/END handshake.
// Define I2C_NACK_ABORT_EN to jump straight to STOP after the first NACKed byte.
module i2c_write_engine
    import i2c_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int I2C_FREQ = 20_000
) (
    input  logic                  iCLK,
    input  logic                  iRST_N,
    input  logic [FRAME_BITS-1:0] iDATA,
    input  logic                  iGO,
    output logic                  oEND,
    output logic                  oACK,
    output logic                  oBUSY,
    output logic                  I2C_SCLK,
    inout  wire                   I2C_SDAT
);

    localparam int QDIV = CLK_FREQ / (4 * I2C_FREQ);

    if (QDIV < 4) begin : g_qdiv_check
        $error("i2c_write_engine: CLK_FREQ/(4*I2C_FREQ) must be at least 4");
    end

    i2c_state_e            state_q, state_d;
    logic [1:0]            qtr_q, qtr_d;
    logic [2:0]            bit_q, bit_d;
    logic [1:0]            byte_q, byte_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic                  nack_q, nack_d;
    logic                  scl_q, scl_d;
    logic                  sda_low_q, sda_low_d;
    logic                  end_q, end_d;
    logic                  busy_q, busy_d;
    logic                  sda_meta_q, sda_sync_q;
    logic                  tick;
    logic                  qclr;

    // Divider is parked at zero whenever no frame is in flight, so the first quarter after accept is full length.
    assign qclr = (state_q == ST_IDLE) || (state_q == ST_DONE);

    i2c_qtick_gen #(.QDIV(QDIV)) u_qtick (
        .clk   (iCLK),
        .rst_n (iRST_N),
        .clr   (qclr),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        nack_d  = nack_q;

        case (state_q)
            ST_IDLE: begin
                if (iGO) begin
                    state_d = ST_START;
                    shift_d = iDATA;
                    nack_d  = 1'b0;
                    qtr_d   = 2'd0;
                    bit_d   = 3'd0;
                    byte_d  = 2'd0;
                end
            end
            ST_START: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) state_d = ST_BIT;
                end
            end
            ST_BIT: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) begin
                        shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if ((qtr_q == 2'd2) && sda_sync_q) nack_d = 1'b1;
                    if (qtr_q == 2'd3) begin
                        byte_d  = byte_q + 2'd1;
                        state_d = (byte_q == 2'd2) ? ST_STOP : ST_BIT;
`ifdef I2C_NACK_ABORT_EN
                        if (nack_q) state_d = ST_STOP;
`endif
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!iGO) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Bus levels are decoded from the next state so the pins are registered and line up with state_q.
        scl_d     = 1'b1;
        sda_low_d = 1'b0;
        case (state_d)
            ST_START: sda_low_d = qtr_d[1];
            ST_BIT: begin
                scl_d     = qtr_d[1];
                sda_low_d = !shift_d[FRAME_BITS-1];
            end
            ST_ACK:   scl_d = qtr_d[1];
            ST_STOP: begin
                scl_d     = (qtr_d != 2'd0);
                sda_low_d = !qtr_d[1];
            end
            default: ;
        endcase

        end_d  = (state_d == ST_DONE);
        busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q    <= ST_IDLE;
            qtr_q      <= 2'd0;
            bit_q      <= 3'd0;
            byte_q     <= 2'd0;
            shift_q    <= '0;
            nack_q     <= 1'b0;
            scl_q      <= 1'b1;
            sda_low_q  <= 1'b0;
            end_q      <= 1'b0;
            busy_q     <= 1'b0;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            qtr_q      <= qtr_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            shift_q    <= shift_d;
            nack_q     <= nack_d;
            scl_q      <= scl_d;
            sda_low_q  <= sda_low_d;
            end_q      <= end_d;
            busy_q     <= busy_d;
            sda_meta_q <= I2C_SDAT;
            sda_sync_q <= sda_meta_q;
        end
    end

    assign I2C_SCLK = scl_q;
    assign I2C_SDAT = sda_low_q ? 1'b0 : 1'bz;
    assign oEND     = end_q;
    assign oBUSY    = busy_q;
    assign oACK     = end_q & nack_q;

endmodule

// File: tb/tb_i2c_write_engine.sv
// Scoreboard bench for i2c_write_engine: a bus decoder/slave and an END monitor pop expected bytes and frame results.
`timescale 1ns/1ps
module tb_i2c_write_engine;

    localparam int CLK_FREQ  = 320;
    localparam int I2C_FREQ  = 20;
    localparam int FRAME_CYC = 464;
`ifdef I2C_NACK_ABORT_EN
    localparam int NACK0_CYC   = 176;
    localparam int NACK0_BYTES = 1;
`else
    localparam int NACK0_CYC   = 464;
    localparam int NACK0_BYTES = 3;
`endif

    typedef struct packed {
        int   lat;
        logic ack;
    } end_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] data = 24'h0;
    logic        go = 1'b0;
    logic        o_end, o_ack, o_busy, scl;
    wire         sda;
    logic        slave_low = 1'b0;

    pullup(sda);
    assign sda = slave_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_write_engine #(.CLK_FREQ(CLK_FREQ), .I2C_FREQ(I2C_FREQ)) dut (
        .iCLK     (clk),
        .iRST_N   (rst_n),
        .iDATA    (data),
        .iGO      (go),
        .oEND     (o_end),
        .oACK     (o_ack),
        .oBUSY    (o_busy),
        .I2C_SCLK (scl),
        .I2C_SDAT (sda)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [7:0] exp_bytes[$];
    end_t       exp_ends[$];
    logic [2:0] nack_mask = 3'b000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bus decoder and ACKing slave, oversampled at the falling clock edge.
    logic       prev_scl = 1'b1, prev_sda = 1'b1, in_frame = 1'b0;
    int         nbits = 0, byte_idx = 0, scl_edges = 0;
    logic [8:0] sh = 9'h0;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame  = 1'b0;
            slave_low = 1'b0;
            nbits     = 0;
        end else if (prev_scl && scl && prev_sda && !sda) begin
            in_frame = 1'b1;
            nbits    = 0;
            byte_idx = 0;
        end else if (prev_scl && scl && !prev_sda && sda) begin
            in_frame = 1'b0;
        end else if (in_frame && !prev_scl && scl) begin
            sh = {sh[7:0], sda};
            nbits++;
            if (nbits == 9) begin
                if (exp_bytes.size() == 0) begin
                    checkOutput("unexpected bus byte", {23'h0, sh}, 32'hFFFF_FFFF);
                end else begin
                    checkOutput("bus byte", {24'h0, sh[8:1]}, {24'h0, exp_bytes.pop_front()});
                end
                if (byte_idx < 3) checkOutput("ack bit", {31'h0, sh[0]}, {31'h0, nack_mask[byte_idx[1:0]]});
                nbits = 0;
                byte_idx++;
            end
        end else if (in_frame && prev_scl && !scl) begin
            slave_low = (nbits == 8) && (byte_idx < 3) && !nack_mask[byte_idx[1:0]];
        end
        if (prev_scl != scl) scl_edges++;
        prev_scl = scl;
        prev_sda = sda;
    end

    // Frame-result monitor: latency from oBUSY rise to oEND rise, plus oACK.
    logic prev_busy = 1'b0, prev_end = 1'b0;
    int   busy_rise_cyc = 0;
    end_t e_pop;

    always @(negedge clk) begin
        if (o_busy && !prev_busy) busy_rise_cyc = cyc;
        if (o_end && !prev_end) begin
            checkOutput("busy low at end", {31'h0, o_busy}, 32'h0);
            if (exp_ends.size() == 0) begin
                checkOutput("unexpected end", {31'h0, o_end}, 32'h0);
            end else begin
                e_pop = exp_ends.pop_front();
                checkOutput("end latency", cyc - busy_rise_cyc, e_pop.lat);
                checkOutput("oACK", {31'h0, o_ack}, {31'h0, e_pop.ack});
            end
        end
        prev_busy = o_busy;
        prev_end  = o_end;
    end

    task automatic applyStimulus(input logic [23:0] frame, input logic [2:0] nack,
                                 input int nbytes, input int lat, input logic ack);
        nack_mask = nack;
        for (int i = 0; i < nbytes; i++) exp_bytes.push_back(frame[23-8*i -: 8]);
        exp_ends.push_back('{lat: lat, ack: ack});
        @(negedge clk);
        data = frame;
        go   = 1'b1;
    endtask

    task automatic waitEnd();
        int n;
        n = 0;
        while (!o_end && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("end seen", {31'h0, o_end}, 32'h1);
    endtask

    task automatic releaseGo();
        @(negedge clk);
        go = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    int          edges0, end_low, busy_hi, deassert_cyc;
    logic [23:0] frame;

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset scl", {31'h0, scl}, 32'h1);
        checkOutput("reset sda", {31'h0, sda}, 32'h1);
        checkOutput("reset end", {31'h0, o_end}, 32'h0);
        checkOutput("reset ack", {31'h0, o_ack}, 32'h0);
        checkOutput("reset busy", {31'h0, o_busy}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] frame 34001A, all ACK, then GO held 100 cycles");
        applyStimulus(24'h34001A, 3'b000, 3, FRAME_CYC, 1'b0);
        waitEnd();
        edges0  = scl_edges;
        end_low = 0;
        repeat (100) begin
            @(negedge clk);
            if (!o_end) end_low++;
        end
        checkOutput("hold end stays high", end_low, 0);
        checkOutput("hold scl quiet", scl_edges - edges0, 0);
        checkOutput("hold ack", {31'h0, o_ack}, 32'h0);
        go = 1'b0;
        @(negedge clk);
        checkOutput("end cleared", {31'h0, o_end}, 32'h0);
        @(negedge clk);

        $display("[TB] address byte NACKed");
        applyStimulus(24'h34001A, 3'b001, NACK0_BYTES, NACK0_CYC, 1'b1);
        waitEnd();
        releaseGo();

        $display("[TB] iDATA changed at quarter 10");
        applyStimulus(24'h34001A, 3'b000, 3, FRAME_CYC, 1'b0);
        repeat (40) @(negedge clk);
        data = 24'hFFFFFF;
        waitEnd();
        releaseGo();

        $display("[TB] reset at quarter 50");
        nack_mask = 3'b000;
        exp_bytes.push_back(8'h34);
        @(negedge clk);
        data = 24'h34001A;
        go   = 1'b1;
        repeat (200) @(posedge clk);
        #2;
        rst_n = 1'b0;
        go    = 1'b0;
        #1;
        checkOutput("mid reset scl", {31'h0, scl}, 32'h1);
        checkOutput("mid reset sda", {31'h0, sda}, 32'h1);
        checkOutput("mid reset busy", {31'h0, o_busy}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        edges0  = scl_edges;
        busy_hi = 0;
        repeat (50) begin
            @(negedge clk);
            if (o_busy || o_end) busy_hi++;
        end
        checkOutput("idle after reset", busy_hi, 0);
        checkOutput("idle scl quiet", scl_edges - edges0, 0);
        checkOutput("bytes after reset", exp_bytes.size(), 0);

        $display("[TB] eleven back-to-back frames");
        deassert_cyc = 0;
        for (int f = 0; f < 11; f++) begin
            frame = {8'h34, f[7:0], 8'h1A ^ f[7:0]};
            applyStimulus(frame, 3'b000, 3, FRAME_CYC, 1'b0);
            waitEnd();
            if (f > 0) checkOutput("restart gap", busy_rise_cyc - deassert_cyc, 2);
            @(negedge clk);
            go = 1'b0;
            deassert_cyc = cyc;
        end
        repeat (5) @(negedge clk);

        checkOutput("leftover bytes", exp_bytes.size(), 0);
        checkOutput("leftover ends", exp_ends.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_write_engine.md
# i2c_write_engine

Bit-level I2C master that serialises one 24-bit write frame {slave address, sub-address, data} onto the open-drain I2C bus. Sits directly downstream of the audio/video codec configuration sequencer: it takes the frame on a level GO / END handshake and reports whether every byte was acknowledged. The block runs on the system clock with an internal quarter-bit tick, so the sequencer needs no divided clock domain.

## Interface
- CLK_FREQ, 50_000_000: iCLK frequency in Hz.
- I2C_FREQ, 20_000: SCL frequency in Hz.
- QDIV (localparam) = CLK_FREQ/(4*I2C_FREQ): iCLK cycles per quarter-bit. QDIV must be ≥4; elaboration error otherwise.

Ports:
- iCLK  in  1  system clock.
- iRST_N  in  1  asynchronous active-low reset.
- iDATA  in  24  frame, transmitted MSB first: [23:16] slave address+R/W, [15:8] sub-address, [7:0] data.
- iGO  in  1  level request; held high until oEND is seen.
- oEND  out  1  transfer complete; held while iGO=1.
- oACK  out  1  1 = at least one NACK in the frame; valid while oEND=1.
- oBUSY  out  1  high from accept until oEND rises.
- I2C_SCLK  out  1  SCL, push-pull.
- I2C_SDAT  inout  1  SDA, open-drain: drives 0 or Z only.

## Operation
- States: IDLE, START, BIT, ACK, STOP, DONE.
- IDLE: SCL=1, SDA=Z. If iGO=1, the block latches iDATA into a shift register, clears the NACK flag and quarter counter, sets oBUSY, and enters START.
- Every state lasts a whole number of quarters, with quarters numbered q0..q3.
- START: q0–q1 SCL=1, SDA=Z; q2–q3 SCL=1, SDA=0.
- BIT (8 per byte): q0–q1 SCL=0; q2–q3 SCL=1. SDA is set to the shift-register MSB at q0 entry (1 → Z). The register shifts left at the end of q3.
- ACK (after each byte): SDA=Z. SCL follows the same pattern as BIT. Synchronised SDA is sampled at the q2→q3 boundary; a sampled 1 sets the NACK flag.
- After the third ACK the block enters STOP. STOP: q0 SCL=0, SDA=0; q1 SCL=1, SDA=0; q2–q3 SCL=1, SDA=Z.
- DONE: oEND=1, oBUSY=0, oACK=NACK flag. While iGO=1 the block stays in DONE and ignores iDATA. When iGO=0 it clears oEND on the next edge and returns to IDLE.
- SDA input passes through a 2-flop synchroniser before sampling.
- Changes to iDATA after accept have no effect.

## Timing
- Reset values: I2C_SCLK=1, SDA=Z, oEND=0, oACK=0, oBUSY=0, state IDLE. Reset is asynchronous, so asserting it mid-frame releases the bus immediately. No bus-recovery sequence is generated.
- Accept happens on the first iCLK edge with IDLE and iGO=1. oBUSY rises on that edge.
- Full frame: 4 + 27×4 + 4 = 116 quarters. oEND rises exactly 116×QDIV cycles after accept.
- The quarter counter width is clog2(QDIV). It wraps to 0 at QDIV−1 and is held at 0 in IDLE and DONE.
- oEND is never high in the same cycle as oBUSY.

## Configuration
- I2C_NACK_ABORT_EN defined: a NACK sampled in any ACK slot skips the remaining bytes and goes directly to STOP. Frame length is 4 + 36·k + 4 quarters, where k is the number of bytes sent up to and including the NACKed byte.
- Undefined: all three bytes are always sent. Length is always 116 quarters, and oACK ORs all three ACK samples.

## Structure
- Package i2c_pkg holds:
  - the state enum;
  - the quarter localparams: START_Q=4, BYTE_Q=36, STOP_Q=4, FRAME_Q=116;
  - FRAME_BITS=24.
- Sub-module i2c_qtick_gen: parameterised QDIV counter producing a one-cycle quarter tick. It has a synchronous clear input, used at accept.

## Test plan
- CLK_FREQ=320, I2C_FREQ=20 (QDIV=4), iDATA=24'h34_001A, slave ACKs all bytes. Required: SDA bits 00110100/00000000/00011010 at the SCL rises, oEND at accept+464 cycles, oACK=0.
- Slave NACKs the address byte.
  - Macro undefined: oEND at +464, oACK=1.
  - Macro defined: STOP right after the first ACK slot, oEND at +176 (44 quarters), oACK=1.
- iGO held 100 cycles after oEND: oEND stays 1 with no SCL activity. iGO→0 clears oEND next cycle. iGO→1 starts a new frame.
- iDATA changed to 24'hFFFFFF at quarter 10: transmitted bits still match the latched 24'h34_001A.
- iRST_N pulled low at quarter 50: I2C_SCLK=1, SDA=Z, oBUSY=0 in the same cycle. After release, the block stays in IDLE until iGO.
- Eleven back-to-back frames driven by the level handshake: each frame's START begins 2 cycles after the previous iGO deassertion plus its reassertion, and all frames complete with oACK=0.
